// File: rtl/player_bullet.sv
// player_bullet: single player bullet for the sprite renderer.
// A fire press arms a launch; the bullet appears on the next frame strobe
// above the player and climbs speed_p rows per frame. It ends when it leaves
// the top of the screen or hits an enemy. A cooldown of cooldown_p frames
// follows before another press is accepted.
//
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   frame_i             one-cycle start-of-frame strobe
//   sx_i, sy_i, de_i    scan position and display enable
//   fire_i              synchronised fire button (level)
//   player_x_i          player sprite left column
//   hit_i               OR of enemy dead outputs
//   bullet_pixel_o      current scan pixel belongs to the bullet
//   bullet_active_o     bullet is flying
//   bullet_x_o/_y_o     bullet top-left corner
//   bullet_r/g/b_o      bullet colour, zero off-bullet
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no bullet; a fire edge arms a launch
// FLYING   | bullet moving up once per frame strobe
// COOLDOWN | bullet gone; waiting cooldown_p frame strobes
module player_bullet #(
  parameter logic [11:0] color_p    = {4'hF, 4'hF, 4'h0},
  parameter logic [9:0]  speed_p    = 10'd4,
  parameter logic [9:0]  start_y_p  = 10'd440,
  parameter logic [9:0]  x_offset_p = 10'd19,
  parameter int unsigned cooldown_p = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_i,
  input  logic [9:0] sx_i,
  input  logic [9:0] sy_i,
  input  logic       de_i,
  input  logic       fire_i,
  input  logic [9:0] player_x_i,
  input  logic       hit_i,
  output logic       bullet_pixel_o,
  output logic       bullet_active_o,
  output logic [9:0] bullet_x_o,
  output logic [9:0] bullet_y_o,
  output logic [3:0] bullet_r_o,
  output logic [3:0] bullet_g_o,
  output logic [3:0] bullet_b_o
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  localparam logic [7:0]  cooldown_lp = 8'(cooldown_p);
  localparam logic [10:0] x_max_lp    = 11'd637;

  state_t      state, state_next;
  logic        fire_q, pending, fire_edge;
  logic [9:0]  bullet_x, bullet_y;
  logic [7:0]  cd_cnt;
  logic        launch, move, enter_cd, cd_done;
  logic [10:0] x_sum;
  logic [9:0]  x_launch;

  assign fire_edge = fire_i & ~fire_q;

  // Launch column clamped so the 2-px bullet stays on a 640-px line.
  assign x_sum    = {1'b0, player_x_i} + {1'b0, x_offset_p};
  assign x_launch = (x_sum > x_max_lp) ? x_max_lp[9:0] : x_sum[9:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    move       = 1'b0;
    enter_cd   = 1'b0;
    cd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (pending && frame_i) begin
          state_next = FLYING;
          launch     = 1'b1;
        end
      end
      FLYING: begin
        // A hit wins over a move in the same cycle.
        if (hit_i) begin
          state_next = COOLDOWN;
          enter_cd   = 1'b1;
        end else if (frame_i) begin
          if (bullet_y < speed_p) begin
            state_next = COOLDOWN;
            enter_cd   = 1'b1;
          end else begin
            move = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        if (frame_i && cd_cnt == 8'd1) begin
          state_next = IDLE;
          cd_done    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // fire_q resets high so a button held through reset produces no edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fire_q   <= 1'b1;
      pending  <= 1'b0;
      bullet_x <= 10'd0;
      bullet_y <= start_y_p;
      cd_cnt   <= 8'd0;
    end else begin
      fire_q <= fire_i;

      if (launch || cd_done)            pending <= 1'b0;
      else if (state == IDLE && fire_edge) pending <= 1'b1;

      if (launch) begin
        bullet_x <= x_launch;
        bullet_y <= start_y_p;
      end else if (move) begin
        bullet_y <= bullet_y - speed_p;
      end

      if (enter_cd)                          cd_cnt <= cooldown_lp;
      else if (state == COOLDOWN && frame_i) cd_cnt <= cd_cnt - 8'd1;
    end
  end

  // 11-bit compares so bullet_x+2 / bullet_y+8 never wrap.
  logic [10:0] sx_e, sy_e, bx_e, by_e;
  assign sx_e = {1'b0, sx_i};
  assign sy_e = {1'b0, sy_i};
  assign bx_e = {1'b0, bullet_x};
  assign by_e = {1'b0, bullet_y};

  assign bullet_pixel_o = (state == FLYING) && de_i &&
                          (sx_e >= bx_e) && (sx_e < bx_e + 11'd2) &&
                          (sy_e >= by_e) && (sy_e < by_e + 11'd8);

  assign bullet_active_o = (state == FLYING);
  assign bullet_x_o      = bullet_x;
  assign bullet_y_o      = bullet_y;
  assign bullet_r_o      = bullet_pixel_o ? color_p[11:8] : 4'h0;
  assign bullet_g_o      = bullet_pixel_o ? color_p[7:4]  : 4'h0;
  assign bullet_b_o      = bullet_pixel_o ? color_p[3:0]  : 4'h0;

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet. Two instances share all inputs: u_dut uses
// default parameters; u_dut2 launches from row 442 so it reaches row 2 and
// exercises the top-exit case with y not a multiple of the speed.
module tb_player_bullet;

  logic       clk_i = 1'b0;
  logic       reset_i, frame_i, de_i, fire_i, hit_i;
  logic [9:0] sx_i, sy_i, player_x_i;

  logic       pix, act, pix2, act2;
  logic [9:0] bx, by, bx2, by2;
  logic [3:0] r, g, b, r2, g2, b2;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  player_bullet u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .frame_i(frame_i), .sx_i(sx_i), .sy_i(sy_i),
    .de_i(de_i), .fire_i(fire_i), .player_x_i(player_x_i), .hit_i(hit_i),
    .bullet_pixel_o(pix), .bullet_active_o(act), .bullet_x_o(bx), .bullet_y_o(by),
    .bullet_r_o(r), .bullet_g_o(g), .bullet_b_o(b)
  );

  player_bullet #(.start_y_p(10'd442)) u_dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .frame_i(frame_i), .sx_i(sx_i), .sy_i(sy_i),
    .de_i(de_i), .fire_i(fire_i), .player_x_i(player_x_i), .hit_i(hit_i),
    .bullet_pixel_o(pix2), .bullet_active_o(act2), .bullet_x_o(bx2), .bullet_y_o(by2),
    .bullet_r_o(r2), .bullet_g_o(g2), .bullet_b_o(b2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_frame();
    frame_i = 1'b1;
    tick();
    frame_i = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) do_frame();
  endtask

  task automatic press();
    fire_i = 1'b1;
    tick();
    fire_i = 1'b0;
    tick();
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic d);
    sx_i = x;
    sy_i = y;
    de_i = d;
    #1;
  endtask

  initial begin
    reset_i = 1'b1; frame_i = 1'b0; de_i = 1'b0; fire_i = 1'b0; hit_i = 1'b0;
    sx_i = '0; sy_i = '0; player_x_i = 10'd100;
    tick(); tick();
    check("rst_active", act, 0);
    check("rst_pixel", pix, 0);
    check("rst_y", by, 440);
    check("rst_x", bx, 0);
    check("rst_r", r, 0);
    reset_i = 1'b0;
    tick();

    // launch
    press();
    check("armed_not_flying", act, 0);
    do_frame();
    check("launch_active", act, 1);
    check("launch_x", bx, 119);
    check("launch_y", by, 440);
    frames(3);
    check("move3_y", by, 428);
    check("move3_x_held", bx, 119);

    // pixel window at (119,300)
    frames(32);
    check("fly_y300", by, 300);
    probe(10'd119, 10'd300, 1'b1);
    check("pix_tl", pix, 1);
    check("pix_tl_r", r, 15);
    check("pix_tl_g", g, 15);
    check("pix_tl_b", b, 0);
    probe(10'd120, 10'd307, 1'b1);
    check("pix_br", pix, 1);
    probe(10'd121, 10'd300, 1'b1);
    check("pix_right_out", pix, 0);
    check("pix_right_out_r", r, 0);
    probe(10'd119, 10'd308, 1'b1);
    check("pix_below_out", pix, 0);
    probe(10'd119, 10'd300, 1'b0);
    check("pix_de0", pix, 0);
    check("pix_de0_g", g, 0);

    // hit on the same cycle as a frame strobe
    hit_i = 1'b1;
    frame_i = 1'b1;
    tick();
    hit_i = 1'b0;
    frame_i = 1'b0;
    check("hit_inactive", act, 0);
    check("hit_y_held", by, 300);
    probe(10'd119, 10'd300, 1'b1);
    check("hit_pixel", pix, 0);
    de_i = 1'b0;
    frames(8);

    // top exit on u_dut2 (y reaches 2), u_dut reaches 0
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tick();
    press();
    do_frame();
    check("exit_launch_y", by2, 442);
    frames(110);
    check("exit_y2", by2, 2);
    check("exit_active_before", act2, 1);
    check("exit_y0", by, 0);
    do_frame();
    check("exit_cooldown", act2, 0);
    check("exit_y_held", by2, 2);
    check("exit0_cooldown", act, 0);
    check("exit0_y_held", by, 0);
    frames(7);
    press();
    do_frame();
    check("cd_no_launch", act2, 0);
    do_frame();
    check("cd_press_dropped", act2, 0);
    press();
    do_frame();
    check("idle_after_8", act2, 1);
    check("relaunch_y", by2, 442);

    // asynchronous reset mid-flight with fire held
    probe(10'd119, 10'd440, 1'b1);
    check("pre_rst_pixel", pix, 1);
    fire_i = 1'b1;
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("async_rst_pixel", pix, 0);
    check("async_rst_active", act, 0);
    check("async_rst_r", r, 0);
    check("async_rst_x", bx, 0);
    tick();
    reset_i = 1'b0;
    tick();
    frames(3);
    check("held_through_rst", act, 0);

    // clamp and held button
    fire_i = 1'b0;
    player_x_i = 10'd630;
    tick();
    fire_i = 1'b1;
    tick();
    do_frame();
    check("clamp_active", act, 1);
    check("clamp_x", bx, 637);
    hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    check("clamp_hit", act, 0);
    frames(8);
    frames(3);
    check("held_one_launch", act, 0);
    fire_i = 1'b0;
    de_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_bullet.md
PLAYER_BULLET -- requirements
Module: player_bullet

Interface
REQ-001 SHALL have parameter color_p, default {4'hF, 4'hF, 4'h0}, the 12-bit RGB of the bullet pixel.
REQ-002 SHALL have parameter speed_p, default 10'd4, the upward pixels moved per frame.
REQ-003 SHALL have parameter start_y_p, default 10'd440, the bullet top row at launch.
REQ-004 SHALL have parameter x_offset_p, default 10'd19, added to player_x_i at launch.
REQ-005 SHALL have parameter cooldown_p, default 8, the frames spent in COOLDOWN (1..255).
REQ-006 SHALL have the following ports, with one clock and an asynchronous, active-high reset:
- clk_i  input  1  clock
- reset_i  input  1  reset
- frame_i  input  1  one-cycle start-of-frame strobe
- sx_i  input  10  scan x
- sy_i  input  10  scan y
- de_i  input  1  display enable
- fire_i  input  1  fire button, already synchronised, level
- player_x_i  input  10  player sprite left column
- hit_i  input  1  OR of all enemy dead_o outputs
- bullet_pixel_o  output  1  current scan pixel is bullet; drives enemy player_top_bullet_pos_i bit 0
- bullet_active_o  output  1  state is FLYING
- bullet_x_o  output  10  bullet left column
- bullet_y_o  output  10  bullet top row
- bullet_r_o, bullet_g_o, bullet_b_o  output  4 each  bullet colour

Function
REQ-007 SHALL implement FSM states IDLE, FLYING and COOLDOWN.
REQ-008 SHALL treat bullet geometry as fixed: width 2 px, height 8 px.
REQ-009 SHALL register fire_i and detect its rising edge; the edge sets a one-bit pending flag only when state is IDLE, and edges in other states are discarded.
REQ-010 SHALL, in IDLE with pending=1 on a frame_i cycle:
- enter FLYING
- clear pending
- load bullet_y = start_y_p
- load bullet_x = min(player_x_i + x_offset_p, 637), computed in 11 bits
REQ-011 SHALL, in FLYING on a frame_i cycle with hit_i=0:
- if bullet_y < speed_p, enter COOLDOWN and leave bullet_y unchanged
- otherwise set bullet_y = bullet_y - speed_p
REQ-012 SHALL, in FLYING on any cycle with hit_i=1, enter COOLDOWN on the next edge; hit_i takes priority over a same-cycle frame_i move.
REQ-013 SHALL hold bullet_x constant while FLYING.
REQ-014 SHALL ignore hit_i in IDLE and COOLDOWN.
REQ-015 SHALL, on COOLDOWN entry, load a frame counter with cooldown_p and decrement it on each frame_i; at counter==1 with frame_i it enters IDLE, so exactly cooldown_p frame strobes are spent in COOLDOWN.
REQ-016 SHALL clear pending on every COOLDOWN to IDLE transition, so a press made during cooldown never fires.
REQ-017 SHALL drive bullet_pixel_o combinationally as FLYING && de_i && sx_i in [bullet_x, bullet_x+2) && sy_i in [bullet_y, bullet_y+8), with comparisons 11 bits wide so there is no wrap.
REQ-018 SHALL drive the colour outputs as color_p nibbles (r = [11:8], g = [7:4], b = [3:0]) when bullet_pixel_o=1, else 4'h0.
REQ-019 SHALL drive bullet_active_o, bullet_x_o and bullet_y_o directly from registers.

Reset
REQ-020 SHALL, when reset_i is asserted, asynchronously force:
- state = IDLE
- pending = 0
- fire register = 1, so a button held through reset does not fire
- bullet_x = 0, bullet_y = start_y_p
- cooldown counter = 0
REQ-021 SHALL hold bullet_pixel_o, bullet_active_o and the colour outputs at 0 while reset_i is high.
REQ-022 SHALL abort a FLYING or COOLDOWN sequence when reset is asserted mid-operation, with no residual pending fire.
REQ-023 SHALL resume normal operation on the first clk_i edge after reset_i deasserts.

Verification
REQ-024 SHALL cover launch: player_x_i=100, fire pulse, then frame_i -> FLYING with x=119, y=440; after 3 further frames y=428.
REQ-025 SHALL cover top exit: speed_p=4 and y=2 at a frame -> COOLDOWN, y stays 2; IDLE after exactly 8 more frames; a fire press during COOLDOWN produces no launch.
REQ-026 SHALL cover hit: hit_i=1 on the same cycle as frame_i while FLYING -> COOLDOWN next cycle, y unchanged, bullet_pixel_o=0 afterwards.
REQ-027 SHALL cover pixel: x=119, y=300, de_i=1; sx/sy=(119,300) and (120,307) -> pixel=1 and RGB=F,F,0; (121,300), (119,308) and de_i=0 -> pixel=0 and RGB=0.
REQ-028 SHALL cover clamp and held button: player_x_i=630 fires at x=637; fire_i held high across multiple frames and through reset -> at most one launch per press and none after reset.
REQ-029 SHALL cover reset mid-flight: reset_i asserted asynchronously while FLYING -> outputs 0 immediately, state IDLE, no launch until a new rising edge on fire_i.
